// File: rtl/mog_frame_sequencer.sv
// mog_frame_sequencer: frame-level controller for the MoG foreground pipeline.
// Issues one raster pixel per cycle into a fixed-latency pipeline, tracks the
// in-flight pixels in a PIPE_LAT-deep delay line, and turns the returning
// foreground flag into a parameter write-back strobe plus a mask beat.
// Optional feature macro: MOG_FG_COUNT_EN adds the fg_count output.
//
// Handshake: a pixel beat transfers on a rising edge where s_valid and s_ready
// are both high. s_ready is combinational from state, credit count and s_sof
// (while hunting for SOF, an SOF beat must wait for a credit; non-SOF beats
// are always taken and dropped). m_mask_valid has no ready: the consumer
// returns one credit per freed entry on m_credit_return.
`timescale 1ns/1ps
module mog_frame_sequencer #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int ADDR_W   = 17,
    parameter int PIPE_LAT = 6,
    parameter int CREDITS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       cfg_fg_threshold,
    input  logic [3:0]        cfg_match_threshold,
    output logic [15:0]       fg_threshold,
    output logic [3:0]        match_threshold,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic [7:0]        s_pixel,
    output logic              pipe_in_valid,
    output logic [ADDR_W-1:0] pipe_in_addr,
    output logic [7:0]        pipe_in_pixel,
    input  logic              pipe_out_is_fg,
    output logic              param_wr_en,
    output logic [ADDR_W-1:0] param_wr_addr,
    output logic              m_mask_valid,
    output logic [7:0]        m_mask_data,
    output logic              m_mask_last,
    input  logic              m_credit_return,
    output logic              busy,
    output logic              frame_done,
    output logic              sof_err
`ifdef MOG_FG_COUNT_EN
    ,
    output logic [ADDR_W:0]   fg_count
`endif
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int CRD_W = $clog2(CREDITS + 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [CRD_W-1:0]  CRD_MAX  = CRD_W'(CREDITS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_SOF = 3'd1,
        S_RUN      = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic issue, start_acc, last_pix, last_col, credit_ok;

    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CRD_W-1:0]  credit_q, credit_d;
    logic [15:0]       fg_thr_q, fg_thr_d;
    logic [3:0]        match_thr_q, match_thr_d;
    logic              sof_err_q, sof_err_d;

    logic              pipe_valid_q, pipe_valid_d;
    logic [ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
    logic [7:0]        pipe_pixel_q, pipe_pixel_d;
    logic              pipe_last_q, pipe_last_d;

    logic [PIPE_LAT-1:0]             dl_valid_q, dl_valid_d;
    logic [PIPE_LAT-1:0]             dl_last_q, dl_last_d;
    logic [PIPE_LAT-1:0][ADDR_W-1:0] dl_addr_q, dl_addr_d;

    logic              mask_valid_q, mask_valid_d;
    logic              mask_fg_q, mask_fg_d;
    logic [ADDR_W-1:0] mask_addr_q, mask_addr_d;
    logic              mask_last_q, mask_last_d;

    assign start_acc = (state_q == S_IDLE) && start;
    assign last_pix  = (pix_cnt_q == LAST_PIX);
    assign last_col  = (col_q == LAST_COL);
    assign credit_ok = (credit_q != '0);

    // Input acceptance: ready per state, and which accepted beats become issues.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            S_WAIT_SOF: s_ready = s_sof ? credit_ok : 1'b1;
            S_RUN:      s_ready = credit_ok;
            default:    s_ready = 1'b0;
        endcase
        issue = s_valid && s_ready &&
                ((state_q == S_RUN) || ((state_q == S_WAIT_SOF) && s_sof));
    end

    // Frame FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_WAIT_SOF;
            S_WAIT_SOF: if (issue) state_d = last_pix ? S_DRAIN : S_RUN;
            S_RUN:      if (issue && last_pix) state_d = S_DRAIN;
            S_DRAIN:    if (!pipe_valid_q && (dl_valid_q == '0)) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Counters, credits, shadows, issue register, delay line and completion stage.
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        col_d     = col_q;
        if (start_acc) begin
            pix_cnt_d = '0;
            col_d     = '0;
        end else if (issue) begin
            pix_cnt_d = last_pix ? '0 : pix_cnt_q + 1'b1;
            col_d     = last_col ? '0 : col_q + 1'b1;
        end

        // A return at full count is dropped; issue plus return cancels out.
        credit_d = credit_q;
        if (issue && !m_credit_return)
            credit_d = credit_q - 1'b1;
        else if (!issue && m_credit_return && (credit_q != CRD_MAX))
            credit_d = credit_q + 1'b1;

        fg_thr_d    = start_acc ? cfg_fg_threshold    : fg_thr_q;
        match_thr_d = start_acc ? cfg_match_threshold : match_thr_q;

        sof_err_d = sof_err_q;
        if (start_acc)
            sof_err_d = 1'b0;
        else if (issue && (state_q == S_RUN) && s_sof)
            sof_err_d = 1'b1;

        pipe_valid_d = issue;
        pipe_addr_d  = issue ? pix_cnt_q : pipe_addr_q;
        pipe_pixel_d = issue ? s_pixel   : pipe_pixel_q;
        pipe_last_d  = issue ? last_col  : pipe_last_q;

        // The delay line starts from the registered issue so its head lines up
        // with the cycle in which the pipeline presents pipe_out_is_fg.
        dl_valid_d    = dl_valid_q;
        dl_last_d     = dl_last_q;
        dl_addr_d     = dl_addr_q;
        dl_valid_d[0] = pipe_valid_q;
        dl_last_d[0]  = pipe_last_q;
        dl_addr_d[0]  = pipe_addr_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_last_d[i]  = dl_last_q[i-1];
            dl_addr_d[i]  = dl_addr_q[i-1];
        end

        mask_valid_d = dl_valid_q[PIPE_LAT-1];
        mask_fg_d    = dl_valid_q[PIPE_LAT-1] && pipe_out_is_fg;
        mask_last_d  = dl_valid_q[PIPE_LAT-1] && dl_last_q[PIPE_LAT-1];
        mask_addr_d  = dl_valid_q[PIPE_LAT-1] ? dl_addr_q[PIPE_LAT-1] : mask_addr_q;
    end

    // State register with synchronous reset; reset also flushes in-flight pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pix_cnt_q    <= '0;
            col_q        <= '0;
            credit_q     <= CRD_MAX;
            fg_thr_q     <= 16'h00FF;
            match_thr_q  <= 4'd5;
            sof_err_q    <= 1'b0;
            pipe_valid_q <= 1'b0;
            pipe_addr_q  <= '0;
            pipe_pixel_q <= '0;
            pipe_last_q  <= 1'b0;
            dl_valid_q   <= '0;
            dl_last_q    <= '0;
            dl_addr_q    <= '0;
            mask_valid_q <= 1'b0;
            mask_fg_q    <= 1'b0;
            mask_addr_q  <= '0;
            mask_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            col_q        <= col_d;
            credit_q     <= credit_d;
            fg_thr_q     <= fg_thr_d;
            match_thr_q  <= match_thr_d;
            sof_err_q    <= sof_err_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_addr_q  <= pipe_addr_d;
            pipe_pixel_q <= pipe_pixel_d;
            pipe_last_q  <= pipe_last_d;
            dl_valid_q   <= dl_valid_d;
            dl_last_q    <= dl_last_d;
            dl_addr_q    <= dl_addr_d;
            mask_valid_q <= mask_valid_d;
            mask_fg_q    <= mask_fg_d;
            mask_addr_q  <= mask_addr_d;
            mask_last_q  <= mask_last_d;
        end
    end

    assign fg_threshold    = fg_thr_q;
    assign match_threshold = match_thr_q;
    assign pipe_in_valid   = pipe_valid_q;
    assign pipe_in_addr    = pipe_addr_q;
    assign pipe_in_pixel   = pipe_pixel_q;
    assign param_wr_en     = mask_valid_q;
    assign param_wr_addr   = mask_addr_q;
    assign m_mask_valid    = mask_valid_q;
    assign m_mask_data     = {8{mask_fg_q}};
    assign m_mask_last     = mask_last_q;
    assign busy            = (state_q != S_IDLE);
    assign frame_done      = (state_q == S_DONE);
    assign sof_err         = sof_err_q;

`ifdef MOG_FG_COUNT_EN
    logic [ADDR_W:0] fg_acc_q, fg_acc_d, fg_count_q, fg_count_d;

    // Count foreground beats this frame; publish the total at frame completion.
    always_comb begin
        fg_acc_d = fg_acc_q;
        if (start_acc)
            fg_acc_d = '0;
        else if (mask_valid_q && mask_fg_q)
            fg_acc_d = fg_acc_q + 1'b1;
        fg_count_d = (state_q == S_DONE) ? fg_acc_q : fg_count_q;
    end

    // Foreground counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fg_acc_q   <= '0;
            fg_count_q <= '0;
        end else begin
            fg_acc_q   <= fg_acc_d;
            fg_count_q <= fg_count_d;
        end
    end

    assign fg_count = fg_count_q;
`endif

endmodule
